// File: rtl/io_bridge.sv
// Byte-wide host bridge: pairs host bytes into 16-bit CPU words, streams CPU results back as two bytes.
// Latency: word pulse 1 cycle after its high byte; read bytes 1 and 2 cycles after out_req.
// Backpressure: none; host writes are always accepted, out_req is dropped while out_busy is high.
// Optional feature macro: IO_BRIDGE_TIMEOUT_EN enables the lone-low-byte timeout and in_drop pulse.
module io_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic [15:0] cpu_data,
    output logic        cpu_read,
    input  logic [15:0] cpu_result,
    input  logic        out_req,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    output logic        out_busy,
    output logic        in_drop
);

    typedef enum logic {
        IN_IDLE,
        IN_HAVE_LO
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_LO,
        OUT_HI
    } out_state_t;

    in_state_t  in_state;
    in_state_t  in_state_nxt;
    out_state_t out_state;
    out_state_t out_state_nxt;

    logic [7:0]  lo_byte;
    logic [15:0] snap;
    logic        take_lo;
    logic        word_done;
    logic        drop_now;
    logic        timed_out;
    logic        load_snap;

`ifdef IO_BRIDGE_TIMEOUT_EN
    // Counter tracks idle cycles spent holding a low byte; it is cleared on
    // every new low byte and the drop fires on the edge it would reach TIMEOUT.
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] wait_cnt;

    assign timed_out = (wait_cnt == CNT_LAST);

    // Idle-cycle counter while a low byte waits; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (take_lo) begin
            wait_cnt <= '0;
        end else if ((in_state == IN_HAVE_LO) && !in_valid && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Registered one-cycle drop pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_drop <= 1'b0;
        end else begin
            in_drop <= drop_now;
        end
    end
`else
    // Without the timeout a low byte waits forever; TIMEOUT has no effect.
    logic timeout_unused;

    assign timed_out      = 1'b0;
    assign in_drop        = 1'b0;
    assign timeout_unused = ^{TIMEOUT, drop_now};
`endif

    // Input FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_state <= IN_IDLE;
        end else begin
            in_state <= in_state_nxt;
        end
    end

    // Input FSM next state: first byte is the low half, second completes the word.
    always_comb begin
        in_state_nxt = in_state;
        take_lo      = 1'b0;
        word_done    = 1'b0;
        drop_now     = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (in_valid) begin
                    take_lo      = 1'b1;
                    in_state_nxt = IN_HAVE_LO;
                end
            end
            IN_HAVE_LO: begin
                // A high byte on the timeout edge still wins over the drop.
                if (in_valid) begin
                    word_done    = 1'b1;
                    in_state_nxt = IN_IDLE;
                end else if (timed_out) begin
                    drop_now     = 1'b1;
                    in_state_nxt = IN_IDLE;
                end
            end
            default: begin
                in_state_nxt = IN_IDLE;
            end
        endcase
    end

    // Input datapath: hold the low byte, publish the word and its one-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_byte  <= 8'h00;
            cpu_data <= 16'h0000;
            cpu_read <= 1'b0;
        end else begin
            cpu_read <= word_done;
            if (take_lo) begin
                lo_byte <= in_byte;
            end
            if (word_done) begin
                cpu_data <= {in_byte, lo_byte};
            end
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_state <= OUT_IDLE;
        end else begin
            out_state <= out_state_nxt;
        end
    end

    // Output FSM next state and byte mux; outputs decode straight from state so
    // reset silences them immediately.
    always_comb begin
        out_state_nxt = out_state;
        load_snap     = 1'b0;
        out_byte      = 8'h00;
        out_valid     = 1'b0;
        out_busy      = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (out_req) begin
                    load_snap     = 1'b1;
                    out_state_nxt = OUT_LO;
                end
            end
            OUT_LO: begin
                out_byte      = snap[7:0];
                out_valid     = 1'b1;
                out_busy      = 1'b1;
                out_state_nxt = OUT_HI;
            end
            OUT_HI: begin
                out_byte      = snap[15:8];
                out_valid     = 1'b1;
                out_busy      = 1'b1;
                out_state_nxt = OUT_IDLE;
            end
            default: begin
                out_state_nxt = OUT_IDLE;
            end
        endcase
    end

    // Snapshot of the CPU result taken on the accepted request edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap <= 16'h0000;
        end else if (load_snap) begin
            snap <= cpu_result;
        end
    end

endmodule
